wb_rr_arbiter: RTL and testbench



---
 rtl/wb_rr_arbiter_if.sv | 48 ++++
 rtl/wb_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between N masters, the arbiter and the downstream address decoder/mux.
// slave: the arbiter's view (it is the slave of the masters); master: the surrounding masters plus bus.
interface wb_rr_arbiter_if #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic [NUM_MASTERS-1:0]            m_cyc_i;
   logic [NUM_MASTERS-1:0]            m_stb_i;
   logic [NUM_MASTERS-1:0]            m_we_i;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
   logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
   logic [DATA_WIDTH-1:0]             m_dat_o;
   logic [NUM_MASTERS-1:0]            m_ack_o;
   logic [NUM_MASTERS-1:0]            m_err_o;

   logic                              s_cyc_o;
   logic                              s_stb_o;
   logic                              s_we_o;
   logic [ADDR_WIDTH-1:0]             s_adr_o;
   logic [DATA_WIDTH-1:0]             s_dat_o;
   logic [SEL_WIDTH-1:0]              s_sel_o;
   logic [DATA_WIDTH-1:0]             s_dat_i;
   logic                              s_ack_i;
   logic                              s_err_i;

   logic [NUM_MASTERS-1:0]            grant_o;
   logic                              timeout_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  s_dat_i, s_ack_i, s_err_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output grant_o, timeout_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output s_dat_i, s_ack_i, s_err_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  grant_o, timeout_o
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone classic arbiter (round-robin or fixed priority) with a stall watchdog.
// Grant 1 cycle after cyc, then combinational forwarding; losers stall on cyc until the owner drops it.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int PRIORITY_MODE  = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic           clk_10M,
   input  logic           sys_rst,
   wb_rr_arbiter_if.slave bus
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH = $clog2(NUM_MASTERS);
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IDX_WIDTH:0]   NM_EXT   = (IDX_WIDTH+1)'(NUM_MASTERS);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic                   timeout_q, timeout_d;

   logic [NUM_MASTERS-1:0] pick;
   logic                   found;
   logic [IDX_WIDTH:0]     cand_sum;
   logic [IDX_WIDTH-1:0]   cand;
   logic [IDX_WIDTH-1:0]   owner_idx;

   logic                   fwd_cyc;
   logic                   fwd_stb;
   logic                   fwd_we;
   logic [ADDR_WIDTH-1:0]  fwd_adr;
   logic [DATA_WIDTH-1:0]  fwd_dat;
   logic [SEL_WIDTH-1:0]   fwd_sel;
   logic                   bus_stb;

   // Search starts at the rr pointer (or at 0 in fixed-priority mode) and wraps.
   always_comb begin
      pick     = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand     = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand_sum = {1'b0, (PRIORITY_MODE != 0) ? '0 : rr_ptr_q} + (IDX_WIDTH+1)'(k);
         if (cand_sum >= NM_EXT) begin
            cand_sum = cand_sum - NM_EXT;
         end
         cand = cand_sum[IDX_WIDTH-1:0];
         if (!found && bus.m_cyc_i[cand]) begin
            pick[cand] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      owner_idx = '0;
      fwd_cyc   = 1'b0;
      fwd_stb   = 1'b0;
      fwd_we    = 1'b0;
      fwd_adr   = '0;
      fwd_dat   = '0;
      fwd_sel   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            owner_idx = IDX_WIDTH'(i);
            fwd_cyc   = bus.m_cyc_i[i];
            fwd_stb   = bus.m_stb_i[i];
            fwd_we    = bus.m_we_i[i];
            fwd_adr   = bus.m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            fwd_dat   = bus.m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            fwd_sel   = bus.m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
         end
      end
   end

   // The forced-error cycle takes the bus off the slave and swallows any late ack.
   assign bus_stb       = fwd_stb & ~timeout_q;
   assign bus.s_cyc_o   = fwd_cyc & ~timeout_q;
   assign bus.s_stb_o   = bus_stb;
   assign bus.s_we_o    = fwd_we;
   assign bus.s_adr_o   = fwd_adr;
   assign bus.s_dat_o   = fwd_dat;
   assign bus.s_sel_o   = fwd_sel;
   assign bus.m_dat_o   = bus.s_dat_i;
   assign bus.m_ack_o   = (bus.s_ack_i && !timeout_q) ? grant_q : '0;
   assign bus.m_err_o   = (bus.s_err_i || timeout_q) ? grant_q : '0;
   assign bus.grant_o   = grant_q;
   assign bus.timeout_o = timeout_q;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = '0;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.m_cyc_i) begin
               state_d = ST_BUSY;
               grant_d = pick;
            end
         end
         ST_BUSY: begin
            if (!fwd_cyc) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               rr_ptr_d = (owner_idx == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0
                                                                     : owner_idx + IDX_WIDTH'(1);
            end else if ((TIMEOUT_CYCLES > 0) && bus_stb && !bus.s_ack_i && !bus.s_err_i) begin
               if (tmo_cnt_q == CNT_LAST) begin
                  timeout_d = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_10M or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed and randomized checks of wb_rr_arbiter: a round-robin instance with a 4-cycle watchdog
// and a fixed-priority instance with the watchdog disabled.
module tb_wb_rr_arbiter;
   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk_10M = 1'b0;
   logic sys_rst;
   always #50 clk_10M = ~clk_10M;

   int checks   = 0;
   int failures = 0;

   // Stimulus for the round-robin instance
   logic [NM-1:0]         m_cyc, m_stb, m_we;
   logic [NM-1:0][AW-1:0] m_adr;
   logic [NM-1:0][DW-1:0] m_wdat;
   logic [NM-1:0][SW-1:0] m_sel;
   logic                  s_ack, s_err;
   logic [DW-1:0]         s_rdat;
   // Stimulus for the fixed-priority instance
   logic [NM-1:0]         f_cyc;
   logic                  f_ack;

   wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rr_if ();
   wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fp_if ();

   assign rr_if.m_cyc_i = m_cyc;
   assign rr_if.m_stb_i = m_stb;
   assign rr_if.m_we_i  = m_we;
   assign rr_if.m_adr_i = m_adr;
   assign rr_if.m_dat_i = m_wdat;
   assign rr_if.m_sel_i = m_sel;
   assign rr_if.s_dat_i = s_rdat;
   assign rr_if.s_ack_i = s_ack;
   assign rr_if.s_err_i = s_err;

   assign fp_if.m_cyc_i = f_cyc;
   assign fp_if.m_stb_i = f_cyc;
   assign fp_if.m_we_i  = '0;
   assign fp_if.m_adr_i = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
   assign fp_if.m_dat_i = '0;
   assign fp_if.m_sel_i = '1;
   assign fp_if.s_dat_i = '0;
   assign fp_if.s_ack_i = f_ack;
   assign fp_if.s_err_i = 1'b0;

   wb_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut_rr (
      .clk_10M (clk_10M),
      .sys_rst (sys_rst),
      .bus     (rr_if)
   );

   wb_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) dut_fp (
      .clk_10M (clk_10M),
      .sys_rst (sys_rst),
      .bus     (fp_if)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_10M);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_10M);
   endtask

   function automatic logic [NM-1:0] oh(input int i);
      oh = (i < 0) ? '0 : NM'(1 << i);
   endfunction

   function automatic int idx_of(input logic [NM-1:0] g);
      idx_of = -1;
      for (int i = 0; i < NM; i++) if (g[i]) idx_of = i;
   endfunction

   // Scratch state for the sequences below
   logic [NM-1:0] term_prev, last_g, g, pend, done;
   int            seq[$], gaps[$];
   int            idle_run, m2_grants, m0_acks, owner, ptr, nxt, lat;
   logic          any_err, any_tmo;

   initial begin
      sys_rst = 1'b1;
      m_cyc = 3'b111; m_stb = 3'b111; m_we = '0; m_adr = '0; m_wdat = '0;
      m_sel[0] = 4'b0001; m_sel[1] = 4'b0010; m_sel[2] = 4'b0100;
      s_ack = 1'b1; s_err = 1'b1; s_rdat = '0;
      f_cyc = 3'b111; f_ack = 1'b0;

      // Reset holds everything quiet even with requests and terminations present
      repeat (3) @(posedge clk_10M);
      smp();
      chk("rst_grant",    rr_if.grant_o,   0);
      chk("rst_scyc",     rr_if.s_cyc_o,   0);
      chk("rst_sstb",     rr_if.s_stb_o,   0);
      chk("rst_sadr",     rr_if.s_adr_o,   0);
      chk("rst_ack",      rr_if.m_ack_o,   0);
      chk("rst_err",      rr_if.m_err_o,   0);
      chk("rst_tmo",      rr_if.timeout_o, 0);
      chk("rst_fp_grant", fp_if.grant_o,   0);
      tick();
      m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; f_cyc = '0;
      sys_rst = 1'b0;

      // Single requester: master 1 read, acked on the third bus cycle
      tick();
      m_cyc = 3'b010; m_stb = 3'b010; m_adr[1] = 32'h8000_0010;
      smp();
      chk("single_idle_grant", rr_if.grant_o, 0);
      chk("single_idle_scyc",  rr_if.s_cyc_o, 0);
      tick(); smp();
      chk("single_grant", rr_if.grant_o, 3'b010);
      chk("single_scyc",  rr_if.s_cyc_o, 1);
      chk("single_sstb",  rr_if.s_stb_o, 1);
      chk("single_sadr",  rr_if.s_adr_o, 32'h8000_0010);
      chk("single_swe",   rr_if.s_we_o,  0);
      chk("single_ssel",  rr_if.s_sel_o, 4'b0010);
      tick(); smp();
      chk("single_wait_ack", rr_if.m_ack_o, 0);
      tick();
      s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
      smp();
      chk("single_ack",  rr_if.m_ack_o, 3'b010);
      chk("single_rdat", rr_if.m_dat_o, 32'hDEAD_BEEF);
      chk("single_err",  rr_if.m_err_o, 0);
      tick();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      smp();
      chk("single_drop_grant", rr_if.grant_o, 3'b010);
      tick(); smp();
      chk("single_release", rr_if.grant_o, 0);

      // Reset while master 2 waits for an ack
      tick();
      m_cyc = 3'b100; m_stb = 3'b100; m_adr[2] = 32'h4000_0020;
      tick(); smp();
      chk("rstmid_grant_before", rr_if.grant_o, 3'b100);
      tick(); smp();
      #10;
      sys_rst = 1'b1; s_ack = 1'b1;
      #1;
      chk("rstmid_grant", rr_if.grant_o, 0);
      chk("rstmid_scyc",  rr_if.s_cyc_o, 0);
      chk("rstmid_ack",   rr_if.m_ack_o, 0);
      chk("rstmid_err",   rr_if.m_err_o, 0);
      tick(); smp();
      chk("rstmid_ack_held", rr_if.m_ack_o, 0);
      m_cyc = '0; m_stb = '0; s_ack = 1'b0;
      #10;
      sys_rst = 1'b0;

      // Round-robin fairness: everyone requests again right after each termination
      term_prev = '0; last_g = '0; idle_run = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         m_cyc = ~term_prev; m_stb = ~term_prev;
         #1;
         s_ack = rr_if.s_stb_o;
         smp();
         term_prev = rr_if.m_ack_o;
         g = rr_if.grant_o;
         if (g == '0) idle_run++;
         else if (g != last_g) begin
            seq.push_back(idx_of(g));
            gaps.push_back(idle_run);
            idle_run = 0;
         end
         last_g = g;
      end
      chk("rr_grant_count", seq.size() >= 6, 1);
      for (int k = 0; k < 6 && k < seq.size(); k++) begin
         chk($sformatf("rr_seq%0d", k), seq[k], k % 3);
         chk($sformatf("rr_gap%0d", k), gaps[k], 1);
      end
      tick();
      m_cyc = '0; m_stb = '0; s_ack = 1'b0;
      tick(); tick();

      // Lock: master 1 keeps the bus for three acked writes while 0 and 2 wait
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      tick();
      m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010; m_wdat[1] = 32'h1111_0000;
      smp();
      tick();
      m_cyc = 3'b011; m_stb = 3'b011;
      smp();
      chk("lock_grant_start", rr_if.grant_o, 3'b010);
      for (int b = 0; b < 3; b++) begin
         tick();
         m_wdat[1] = 32'h1111_0000 + 32'(b);
         s_ack = 1'b1;
         if (b == 1) begin m_cyc[2] = 1'b1; m_stb[2] = 1'b1; end
         smp();
         chk($sformatf("lock_grant%0d", b), rr_if.grant_o, 3'b010);
         chk($sformatf("lock_ack%0d", b),   rr_if.m_ack_o, 3'b010);
         chk($sformatf("lock_sdat%0d", b),  rr_if.s_dat_o, 32'h1111_0000 + 32'(b));
         chk($sformatf("lock_swe%0d", b),   rr_if.s_we_o,  1);
      end
      tick();
      s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      smp();
      chk("lock_drop_grant", rr_if.grant_o, 3'b010);
      tick(); smp();
      chk("lock_idle", rr_if.grant_o, 0);
      tick(); smp();
      chk("lock_next_owner", rr_if.grant_o, 3'b100);
      m_cyc = '0; m_stb = '0; m_we = '0;
      tick(); tick(); tick();

      // Watchdog: four unanswered stall cycles, then a one-cycle forced error
      tick();
      m_cyc = 3'b001; m_stb = 3'b001; m_adr[0] = 32'hDEAD_0000;
      smp();
      for (int k = 0; k < 4; k++) begin
         tick(); smp();
         chk($sformatf("to_stall_err%0d", k),  rr_if.m_err_o,   0);
         chk($sformatf("to_stall_tmo%0d", k),  rr_if.timeout_o, 0);
         chk($sformatf("to_stall_scyc%0d", k), rr_if.s_cyc_o,   1);
      end
      tick();
      s_ack = 1'b1;
      smp();
      chk("to_fire_err",   rr_if.m_err_o,   3'b001);
      chk("to_fire_tmo",   rr_if.timeout_o, 1);
      chk("to_fire_scyc",  rr_if.s_cyc_o,   0);
      chk("to_fire_sstb",  rr_if.s_stb_o,   0);
      chk("to_late_ack",   rr_if.m_ack_o,   0);
      chk("to_fire_grant", rr_if.grant_o,   3'b001);
      tick();
      s_ack = 1'b0;
      smp();
      chk("to_after_err",   rr_if.m_err_o,   0);
      chk("to_after_tmo",   rr_if.timeout_o, 0);
      chk("to_after_scyc",  rr_if.s_cyc_o,   1);
      chk("to_after_grant", rr_if.grant_o,   3'b001);
      for (int k = 0; k < 2; k++) begin
         tick(); smp();
         chk($sformatf("to_retry_err%0d", k), rr_if.m_err_o, 0);
      end
      // Ack lands exactly on the threshold stall cycle: ack wins
      tick();
      s_ack = 1'b1;
      smp();
      chk("to_edge_ack",  rr_if.m_ack_o, 3'b001);
      chk("to_edge_scyc", rr_if.s_cyc_o, 1);
      tick();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      smp();
      chk("to_edge_noerr", rr_if.m_err_o,   0);
      chk("to_edge_notmo", rr_if.timeout_o, 0);
      tick(); smp();
      chk("to_release", rr_if.grant_o, 0);

      // Ack and err together are both forwarded
      tick();
      m_cyc = 3'b001; m_stb = 3'b001;
      tick();
      s_ack = 1'b1; s_err = 1'b1;
      smp();
      chk("both_ack", rr_if.m_ack_o, 3'b001);
      chk("both_err", rr_if.m_err_o, 3'b001);
      tick();
      s_ack = 1'b0; s_err = 1'b0; m_cyc = '0; m_stb = '0;
      tick(); tick();

      // Fixed priority: master 0 keeps re-requesting, master 2 must starve
      term_prev = '0; m2_grants = 0; m0_acks = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         f_cyc = 3'b101 & ~term_prev;
         #1;
         f_ack = fp_if.s_stb_o;
         smp();
         term_prev = fp_if.m_ack_o;
         if (fp_if.grant_o[2]) m2_grants++;
         if (fp_if.m_ack_o[0]) m0_acks++;
      end
      chk("fp_m2_starved", m2_grants, 0);
      chk("fp_m0_acks",    m0_acks,   13);

      // Watchdog disabled: a long stall never errors
      any_err = 1'b0; any_tmo = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         f_cyc = 3'b100; f_ack = 1'b0;
         smp();
         any_err = any_err | (|fp_if.m_err_o);
         any_tmo = any_tmo | fp_if.timeout_o;
      end
      chk("fp_nowd_grant", fp_if.grant_o, 3'b100);
      chk("fp_nowd_err",   any_err,       0);
      chk("fp_nowd_tmo",   any_tmo,       0);
      tick();
      f_cyc = '0;

      // Randomized traffic against a rule-level model of ownership
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      owner = -1; ptr = 0; pend = '0; done = '0; lat = 0;
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int i = 0; i < NM; i++) begin
            if (done[i]) begin
               pend[i] = 1'b0; done[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]   = 1'b1;
               m_adr[i]  = $urandom;
               m_wdat[i] = $urandom;
               m_we[i]   = 1'($urandom_range(0, 1));
            end
         end
         m_cyc = pend; m_stb = pend;
         s_ack = 1'b0; s_err = 1'b0; s_rdat = $urandom;
         #1;
         if (rr_if.s_stb_o) begin
            if (lat == 0) begin
               if ($urandom_range(0, 4) == 0) s_err = 1'b1;
               else s_ack = 1'b1;
               lat = $urandom_range(0, 2);
            end else lat--;
         end
         smp();
         chk("rnd_grant", rr_if.grant_o, oh(owner));
         chk("rnd_sadr",  rr_if.s_adr_o, (owner >= 0) ? m_adr[owner] : 32'h0);
         chk("rnd_ack",   rr_if.m_ack_o, s_ack ? oh(owner) : 3'b000);
         chk("rnd_err",   rr_if.m_err_o, s_err ? oh(owner) : 3'b000);
         chk("rnd_rdat",  rr_if.m_dat_o, s_rdat);
         if (owner >= 0 && (s_ack || s_err)) done[owner] = 1'b1;
         if (owner < 0) begin
            nxt = -1;
            for (int k = 0; k < NM; k++)
               if (nxt < 0 && m_cyc[(ptr + k) % NM]) nxt = (ptr + k) % NM;
            owner = nxt;
         end else if (!m_cyc[owner]) begin
            ptr   = (owner + 1) % NM;
            owner = -1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
